// File: rtl/interrupt_acknowledge_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_acknowledge_sequencer
//
// CPU-side bus master placed directly upstream of an 8259A-style interrupt
// controller. It does one of two jobs at a time:
//   * Runs register write/read cycles (ICW/OCW programming, IRR/ISR/IMR
//     reads) for a synchronous host using a valid/ready command handshake.
//   * When the controller raises interrupt_to_cpu (and ack_enable=1), runs
//     the two-pulse 8086 INTA sequence and hands the captured vector byte to
//     the host via a valid/ready handshake.
// All strobes are registered, so the controller sees glitch-free pins.
//
// Parameters
//   PULSE_CYCLES  clocks each strobe (RD/WR/INTA) is held low   (1..15)
//   GAP_CYCLES    clocks all strobes are high between/after INTA (1..15)
//   SYNC_STAGES   flops synchronising interrupt_to_cpu           (2..3)
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   interrupt_to_cpu          asynchronous INT from the controller
//   ack_enable                1 = service interrupts (CPU IF flag)
//   cmd_valid/cmd_ready       host command handshake
//   cmd_write/cmd_address     cycle type and A0
//   cmd_write_data            byte driven on write cycles
//   read_data_valid/read_data one-cycle pulse with the byte read
//   vector_valid/vector_ready vector handshake to the host
//   vector                    byte captured during the second INTA pulse
//   chip_select_n, read_enable_n, write_enable_n, address,
//   interrupt_acknowledge_n   controller bus pins
//   data_bus_out/data_bus_drive  byte and tristate enable toward the controller
//   data_bus_in               byte sampled from the controller's data bus
//   busy                      1 whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module interrupt_acknowledge_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_to_cpu,
  input  logic       ack_enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_address,
  input  logic [7:0] cmd_write_data,
  output logic       read_data_valid,
  output logic [7:0] read_data,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic [7:0] vector,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       address,
  output logic       interrupt_acknowledge_n,
  output logic [7:0] data_bus_out,
  output logic       data_bus_drive,
  input  logic [7:0] data_bus_in,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_SETUP,
    S_CMD_STROBE,
    S_CMD_HOLD,
    S_ACK1,
    S_GAP1,
    S_ACK2,
    S_GAP2,
    S_VECTOR_OUT
  } state_t;

  // Counters hold "cycles remaining minus one", so a state ends when the
  // counter reads zero.
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t                 r_state;
  logic [3:0]             r_count;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_is_write;

  logic       r_cmd_ready;
  logic       r_read_data_valid;
  logic [7:0] r_read_data;
  logic       r_vector_valid;
  logic [7:0] r_vector;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_address;
  logic       r_inta_n;
  logic [7:0] r_data_bus_out;
  logic       r_data_bus_drive;
  logic       r_busy;

  logic w_int_sync;
  logic w_count_done;

  assign w_int_sync   = r_sync[SYNC_STAGES-1];
  assign w_count_done = (r_count == 4'd0);

  // Every output field is set on the edge that enters the state it belongs
  // to, so outputs always line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_count           <= 4'd0;
      r_sync            <= '0;
      r_is_write        <= 1'b0;
      r_cmd_ready       <= 1'b0;
      r_read_data_valid <= 1'b0;
      r_read_data       <= 8'h00;
      r_vector_valid    <= 1'b0;
      r_vector          <= 8'h00;
      r_cs_n            <= 1'b1;
      r_rd_n            <= 1'b1;
      r_wr_n            <= 1'b1;
      r_address         <= 1'b0;
      r_inta_n          <= 1'b1;
      r_data_bus_out    <= 8'h00;
      r_data_bus_drive  <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, so the shift chain and state updates are
      // order-independent.
      r_sync            <= {r_sync[SYNC_STAGES-2:0], interrupt_to_cpu};
      r_read_data_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A command accepted this cycle beats a pending interrupt.
          if (cmd_valid && r_cmd_ready) begin
            r_state          <= S_CMD_SETUP;
            r_cmd_ready      <= 1'b0;
            r_busy           <= 1'b1;
            r_cs_n           <= 1'b0;
            r_address        <= cmd_address;
            r_data_bus_out   <= cmd_write_data;
            r_data_bus_drive <= cmd_write;
            r_is_write       <= cmd_write;
          end else if (w_int_sync && ack_enable) begin
            r_state     <= S_ACK1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_inta_n    <= 1'b0;
            r_count     <= PULSE_LOAD;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_CMD_SETUP: begin
          r_state <= S_CMD_STROBE;
          r_count <= PULSE_LOAD;
          r_wr_n  <= ~r_is_write;
          r_rd_n  <= r_is_write;
        end

        S_CMD_STROBE: begin
          if (w_count_done) begin
            r_state <= S_CMD_HOLD;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            // Sampled at the end of the last strobe cycle, when the
            // controller's read data has had the whole pulse to settle.
            if (!r_is_write) begin
              r_read_data       <= data_bus_in;
              r_read_data_valid <= 1'b1;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_CMD_HOLD: begin
          r_state          <= S_IDLE;
          r_cs_n           <= 1'b1;
          r_data_bus_drive <= 1'b0;
          r_busy           <= 1'b0;
          r_cmd_ready      <= 1'b1;
        end

        S_ACK1: begin
          if (w_count_done) begin
            r_state  <= S_GAP1;
            r_inta_n <= 1'b1;
            r_count  <= GAP_LOAD;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_GAP1: begin
          if (w_count_done) begin
            r_state  <= S_ACK2;
            r_inta_n <= 1'b0;
            r_count  <= PULSE_LOAD;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_ACK2: begin
          if (w_count_done) begin
            r_state  <= S_GAP2;
            r_inta_n <= 1'b1;
            r_vector <= data_bus_in;
            r_count  <= GAP_LOAD;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_GAP2: begin
          if (w_count_done) begin
            r_state        <= S_VECTOR_OUT;
            r_vector_valid <= 1'b1;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_VECTOR_OUT: begin
          if (vector_ready) begin
            r_state        <= S_IDLE;
            r_vector_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_cmd_ready    <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready               = r_cmd_ready;
  assign read_data_valid         = r_read_data_valid;
  assign read_data               = r_read_data;
  assign vector_valid            = r_vector_valid;
  assign vector                  = r_vector;
  assign chip_select_n           = r_cs_n;
  assign read_enable_n           = r_rd_n;
  assign write_enable_n          = r_wr_n;
  assign address                 = r_address;
  assign interrupt_acknowledge_n = r_inta_n;
  assign data_bus_out            = r_data_bus_out;
  assign data_bus_drive          = r_data_bus_drive;
  assign busy                    = r_busy;

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_acknowledge_sequencer
//
// Self-checking bench. A bus monitor measures strobe widths, logs write
// cycles and plays the controller's side of the data bus (read byte or
// vector, presented only on the last cycle of the relevant pulse). Directed
// scenarios are followed by a randomized mix of writes, reads and interrupts
// whose expected results come from the command/vector values themselves and
// from the configured pulse/gap/synchroniser lengths.
// ---------------------------------------------------------------------------
module tb_interrupt_acknowledge_sequencer;

  localparam int PULSE = 2;
  localparam int GAP   = 1;
  localparam int SYNC  = 2;
  localparam int BOUND = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       interrupt_to_cpu = 1'b0;
  logic       ack_enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic       cmd_address = 1'b0;
  logic [7:0] cmd_write_data = 8'h00;
  logic       read_data_valid;
  logic [7:0] read_data;
  logic       vector_valid;
  logic       vector_ready = 1'b0;
  logic [7:0] vector;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic       address;
  logic       interrupt_acknowledge_n;
  logic [7:0] data_bus_out;
  logic       data_bus_drive;
  logic [7:0] data_bus_in = 8'hEE;
  logic       busy;

  interrupt_acknowledge_sequencer #(
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAP),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .interrupt_to_cpu       (interrupt_to_cpu),
    .ack_enable             (ack_enable),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_write              (cmd_write),
    .cmd_address            (cmd_address),
    .cmd_write_data         (cmd_write_data),
    .read_data_valid        (read_data_valid),
    .read_data              (read_data),
    .vector_valid           (vector_valid),
    .vector_ready           (vector_ready),
    .vector                 (vector),
    .chip_select_n          (chip_select_n),
    .read_enable_n          (read_enable_n),
    .write_enable_n         (write_enable_n),
    .address                (address),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .data_bus_out           (data_bus_out),
    .data_bus_drive         (data_bus_drive),
    .data_bus_in            (data_bus_in),
    .busy                   (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- bus monitor / controller model ----------------
  typedef struct {
    logic       a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_log[$];
  wr_t        wr_exp[$];
  wr_t        wr_seen;
  int         cs_run = 0, cs_width = 0;
  int         drive_run = 0, drive_width = 0, drive_total = 0;
  int         wr_run = 0, wr_width = 0, wr_start_cs = 0;
  int         rd_run = 0, rd_width = 0;
  logic       rd_addr_seen = 1'b0;
  int         inta_run = 0, inta_width = 0, inta_first_width = 0;
  int         inta_gap = 0, hi_run = 0, inta_pulses = 0;
  int         rdv_count = 0;
  logic [7:0] rdv_data = 8'h00;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] vec_byte = 8'h00;

  always @(posedge clock) begin
    logic ok;
    #1;
    if (reset) begin
      cs_run = 0; drive_run = 0; wr_run = 0; rd_run = 0;
      inta_run = 0; inta_pulses = 0; hi_run = 0;
      data_bus_in = 8'hEE;
    end else begin
      if (!chip_select_n) cs_run++;
      else if (cs_run != 0) begin cs_width = cs_run; cs_run = 0; end

      if (data_bus_drive) begin drive_run++; drive_total++; end
      else if (drive_run != 0) begin drive_width = drive_run; drive_run = 0; end

      if (!write_enable_n) begin
        if (wr_run == 0) wr_start_cs = cs_run;
        wr_run++;
        wr_seen.a = address;
        wr_seen.d = data_bus_out;
      end else if (wr_run != 0) begin
        wr_width = wr_run; wr_run = 0; wr_log.push_back(wr_seen);
      end

      if (!read_enable_n) begin
        rd_run++;
        rd_addr_seen = address;
      end else if (rd_run != 0) begin
        rd_width = rd_run; rd_run = 0;
      end

      if (!interrupt_acknowledge_n) begin
        if (inta_run == 0) begin inta_pulses++; inta_gap = hi_run; end
        inta_run++;
        hi_run = 0;
      end else begin
        if (inta_run != 0) begin
          if (inta_pulses % 2 == 1) inta_first_width = inta_run;
          else inta_width = inta_run;
          inta_run = 0;
        end
        hi_run++;
      end

      if (read_data_valid) begin rdv_count++; rdv_data = read_data; end

      // Controller side: valid data only on the final cycle of a pulse.
      if (!interrupt_acknowledge_n && (inta_pulses % 2 == 0) && inta_run == PULSE)
        data_bus_in = vec_byte;
      else if (!read_enable_n && rd_run == PULSE)
        data_bus_in = rd_byte;
      else
        data_bus_in = 8'hEE;
    end

    ok = ((int'(!read_enable_n) + int'(!write_enable_n) + int'(!interrupt_acknowledge_n)) <= 1)
         && ((read_enable_n && write_enable_n) || !chip_select_n)
         && (!data_bus_drive || !chip_select_n);
    check("bus_protocol", 32'(ok), 32'd1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input string tag);
    int guard = 0;
    while (busy && guard < BOUND) begin @(negedge clock); guard++; end
    check(tag, 32'(guard < BOUND), 32'd1);
  endtask

  task automatic do_cmd(input logic w, input logic a, input logic [7:0] d);
    int guard = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_write_data = d;
    while (!cmd_ready && guard < BOUND) begin @(negedge clock); guard++; end
    check("cmd_accept_timeout", 32'(guard < BOUND), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_idle("cmd_done_timeout");
  endtask

  task automatic check_write_log();
    wr_t got, exp;
    check("wr_log_size", wr_log.size(), wr_exp.size());
    while (wr_log.size() > 0 && wr_exp.size() > 0) begin
      got = wr_log.pop_front();
      exp = wr_exp.pop_front();
      check("wr_address", 32'(got.a), 32'(exp.a));
      check("wr_data", 32'(got.d), 32'(exp.d));
    end
    wr_log.delete();
    wr_exp.delete();
  endtask

  task automatic write_op(input logic a, input logic [7:0] d);
    wr_exp.push_back('{a: a, d: d});
    do_cmd(1'b1, a, d);
    check("wr_width", wr_width, PULSE);
    check("wr_start", wr_start_cs, 2);
    check("wr_cs_width", cs_width, PULSE + 2);
    check("wr_drive_width", drive_width, PULSE + 2);
    check_write_log();
  endtask

  task automatic read_op(input logic a, input logic [7:0] b);
    int rdv0 = rdv_count;
    int drv0 = drive_total;
    rd_byte = b;
    do_cmd(1'b0, a, 8'h5A);
    check("rd_valid_pulses", rdv_count - rdv0, 1);
    check("rd_data_pulse", 32'(rdv_data), 32'(b));
    check("rd_data_held", 32'(read_data), 32'(b));
    check("rd_width", rd_width, PULSE);
    check("rd_address", 32'(rd_addr_seen), 32'(a));
    check("rd_cs_width", cs_width, PULSE + 2);
    check("rd_no_drive", drive_total - drv0, 0);
  endtask

  task automatic int_op(input logic [7:0] v, input int delay, input bit check_latency);
    int p0 = inta_pulses;
    int n = 0;
    vec_byte = v;
    @(negedge clock);
    interrupt_to_cpu = 1'b1;
    ack_enable = 1'b1;
    // Count rising edges until the first INTA low.
    while (n < BOUND) begin
      @(posedge clock); #2; n++;
      if (!interrupt_acknowledge_n) break;
    end
    check("inta_start_timeout", 32'(n < BOUND), 32'd1);
    if (check_latency) check("int_latency", n, SYNC + 1);
    // Dropping INT now must not abort the pair.
    interrupt_to_cpu = 1'b0;
    n = 0;
    while (!vector_valid && n < BOUND) begin @(negedge clock); n++; end
    check("vector_timeout", 32'(n < BOUND), 32'd1);
    check("inta_pulse_count", inta_pulses - p0, 2);
    check("inta1_width", inta_first_width, PULSE);
    check("inta2_width", inta_width, PULSE);
    check("inta_gap", inta_gap, GAP);
    check("vector_value", 32'(vector), 32'(v));
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      check("vector_hold_valid", 32'(vector_valid), 32'd1);
      check("vector_hold_value", 32'(vector), 32'(v));
    end
    vector_ready = 1'b1;
    @(negedge clock);
    vector_ready = 1'b0;
    check("vector_released", 32'(vector_valid), 32'd0);
    check("idle_after_vector", 32'(busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    int n;

    // Reset held for three clocks.
    repeat (3) @(posedge clock);
    #2;
    check("rst_strobes", 32'({chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n}), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vector_valid", 32'(vector_valid), 32'd0);
    check("rst_drive", 32'({data_bus_drive, data_bus_out}), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // ICW1 then ICW2.
    write_op(1'b0, 8'h13);
    write_op(1'b1, 8'h20);

    // Read while controller drives 0xFB.
    read_op(1'b1, 8'hFB);

    // Interrupt with vector 0x21, host stalls 5 clocks.
    int_op(8'h21, 5, 1'b1);

    // ack_enable=0 with INT high: nothing happens.
    @(negedge clock);
    ack_enable = 1'b0;
    interrupt_to_cpu = 1'b1;
    p0 = inta_pulses;
    repeat (20) @(negedge clock);
    check("no_inta_when_disabled", inta_pulses - p0, 0);
    check("idle_when_disabled", 32'(busy), 32'd0);

    // Command and interrupt in the same IDLE cycle: command first.
    check("same_cycle_ready", 32'(cmd_ready), 32'd1);
    vec_byte = 8'h4C;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 1'b0; cmd_write_data = 8'h0B;
    ack_enable = 1'b1;
    wr_exp.push_back('{a: 1'b0, d: 8'h0B});
    @(posedge clock); #2;
    check("same_cycle_cmd_wins", 32'({chip_select_n, interrupt_acknowledge_n}), 32'b01);
    @(negedge clock);
    cmd_valid = 1'b0;
    n = 0;
    while (interrupt_acknowledge_n && n < BOUND) begin @(negedge clock); n++; end
    check("ack_after_cmd_timeout", 32'(n < BOUND), 32'd1);
    interrupt_to_cpu = 1'b0;
    check_write_log();
    // Wait for the second INTA pulse, then request a read.
    n = 0;
    while (!((inta_pulses - p0) == 2 && !interrupt_acknowledge_n) && n < BOUND) begin
      @(negedge clock); n++;
    end
    check("ack2_timeout", 32'(n < BOUND), 32'd1);
    rd_byte = 8'hC3;
    p0 = rdv_count;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 1'b1;
    check("cmd_blocked_in_ack2", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!vector_valid && n < BOUND) begin @(negedge clock); n++; end
    check("vector2_timeout", 32'(n < BOUND), 32'd1);
    check("vector2_value", 32'(vector), 32'h4C);
    check("cs_high_in_vector_out", 32'({chip_select_n, cmd_ready}), 32'b10);
    vector_ready = 1'b1;
    @(negedge clock);
    vector_ready = 1'b0;
    check("cmd_ready_after_vector", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_idle("deferred_read_timeout");
    check("deferred_read_pulses", rdv_count - p0, 1);
    check("deferred_read_data", 32'(read_data), 32'hC3);

    // Reset in the middle of ACK1.
    @(negedge clock);
    interrupt_to_cpu = 1'b1;
    n = 0;
    while (interrupt_acknowledge_n && n < BOUND) begin @(negedge clock); n++; end
    check("ack1_for_reset_timeout", 32'(n < BOUND), 32'd1);
    reset = 1'b1;
    interrupt_to_cpu = 1'b0;
    @(posedge clock); #2;
    check("midreset_strobes", 32'({chip_select_n, read_enable_n, write_enable_n, interrupt_acknowledge_n}), 32'hF);
    check("midreset_busy_valid", 32'({busy, vector_valid}), 32'b00);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("post_reset_idle", 32'({busy, interrupt_acknowledge_n}), 32'b01);

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: write_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        1: read_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        default: int_op(8'($urandom_range(0, 255)), $urandom_range(0, 4), 1'b0);
      endcase
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
